instr_encoder_writer: RTL

//  Inverse of the opcode control decoder. Accepts a control-signal bundle plus register/immediate fields over valid/ready.
//  Re-encodes the bundle into the 2-bit opcode and packs a 16-bit instruction word.

---
 rtl/instr_encoder_writer_if.sv | 43 ++++
 rtl/instr_encoder_writer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/instr_encoder_writer_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_writer_if
//   Bundles the request handshake (control bundle + register/immediate fields)
//   and the instruction-memory write port of instr_encoder_writer.
//   master : loader side (drives the request, observes ready and memory port)
//   slave  : encoder side (consumes the request, drives ready and memory port)
// Parameters
//   ADDR_W   instruction-memory address width (must match the encoder's)
//   INSTR_W  instruction word width (16)
// ---------------------------------------------------------------------------
interface instr_encoder_writer_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic               RegDst;
    logic               AluSrc;
    logic               MemToReg;
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               AluOp;
    logic [1:0]         rs;
    logic [1:0]         rt;
    logic [1:0]         rd;
    logic [7:0]         low8;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (
        output in_valid, RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite,
               AluOp, rs, rt, rd, low8,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite,
               AluOp, rs, rt, rd, low8,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_writer.sv
// ---------------------------------------------------------------------------
// instr_encoder_writer
//   Re-encodes a decoded control bundle into the 2-bit opcode, packs a 16-bit
//   instruction word {op, rs, rt, rd, low8} and streams accepted words into
//   instruction memory at consecutive addresses starting from 0.
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous active-high reset
//   i_clear        synchronous restart of pointer/count/full/halt
//   bus            instr_encoder_writer_if.slave (request + imem write port)
//   o_count        words written since reset/clear (ADDR_W+1 bits)
//   o_full         memory filled, no more words accepted until clear/reset
//   o_err_illegal  one-cycle pulse after an illegal bundle is accepted
// Configuration
//   ENC_ERR_HALT_EN  when defined, an illegal bundle sets a sticky halt that
//                    blocks further input until clear/reset. When undefined
//                    illegal requests are dropped and streaming continues.
// ---------------------------------------------------------------------------
module instr_encoder_writer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    instr_encoder_writer_if.slave   bus,
    output logic [ADDR_W:0]         o_count,
    output logic                    o_full,
    output logic                    o_err_illegal
);

    // count value while the write to the last address is in flight
    localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    logic [6:0]         w_bundle;
    logic               w_legal;
    logic [1:0]         w_opc;
    logic [15:0]        w_word;
    logic               w_fire;
    logic               w_halt;
    logic               w_last_pending;

    logic               r_we;
    logic [INSTR_W-1:0] r_wdata;
    logic               r_err;
    logic [ADDR_W:0]    r_count;

    assign w_bundle = {bus.RegDst, bus.AluSrc, bus.MemToReg, bus.RegWrite,
                       bus.MemRead, bus.MemWrite, bus.AluOp};

    always_comb begin
        w_legal = 1'b1;
        w_opc   = 2'b00;
        case (w_bundle)
            7'b1001001: w_opc = 2'b00;  // R
            7'b0101001: w_opc = 2'b01;  // ADDI
            7'b0111100: w_opc = 2'b10;  // LW
            7'b0100010: w_opc = 2'b11;  // SW
            default:    w_legal = 1'b0;
        endcase
    end

    // rd only carries meaning for R-format; I-formats zero it
    assign w_word = {w_opc, bus.rs, bus.rt,
                     (w_opc == 2'b00) ? bus.rd : 2'b00, bus.low8};

    // The count only advances one cycle after acceptance, so the last slot is
    // also closed while its write is still in flight; otherwise a continuous
    // stream would slip one word past the end of memory.
    assign w_last_pending = r_we && (r_count == LAST_SLOT);

    assign bus.in_ready = !i_reset && !i_clear && !o_full && !w_last_pending && !w_halt;
    assign w_fire       = bus.in_valid && bus.in_ready;

`ifdef ENC_ERR_HALT_EN
    logic r_halt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear)
            r_halt <= 1'b0;
        else if (w_fire && !w_legal)
            r_halt <= 1'b1;
    end

    assign w_halt = r_halt;
`else
    assign w_halt = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_we  <= w_fire && w_legal;
            r_err <= w_fire && !w_legal;
            if (w_fire && w_legal)
                r_wdata <= w_word;
            // a write registered in the clear cycle still goes out at its old
            // address, but is not counted in the fresh run
            if (i_clear)
                r_count <= '0;
            else if (r_we)
                r_count <= r_count + 1'b1;
        end
    end

    // the write pointer is the low part of the count: it still holds the
    // pending word's address during the write cycle
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_count[ADDR_W-1:0];
    assign bus.imem_wdata = r_wdata;

    assign o_count       = r_count;
    assign o_full        = r_count[ADDR_W];
    assign o_err_illegal = r_err;

endmodule
